// File: rtl/mac_acc_pipe.sv
// Pipelined N-lane multiply-accumulate for the psum write path. It registers the lane
// products, then adds them and accumulates. It holds one psum at a valid/ready output.
module mac_acc_pipe #(
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter int lanes   = 4,
    parameter int len_bw  = 8,
    parameter bit sat_en  = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [lanes*bw-1:0] a,
    input  logic [lanes*bw-1:0] b,
    input  logic [psum_bw-1:0]  c_in,
    input  logic [len_bw-1:0]   acc_len,
    input  logic                act_signed,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [psum_bw-1:0]  out,
    output logic                ovf
);
    localparam int pw = 2 * bw + 1;
    localparam int lg = $clog2(lanes);
    localparam int sw = pw + lg;
    localparam int aw = psum_bw + 1;

    function automatic logic is_ovf(input logic signed [aw-1:0] v);
        return v[aw-1] != v[aw-2];
    endfunction

    function automatic logic signed [psum_bw-1:0] sat_psum(input logic signed [aw-1:0] v);
        if (sat_en && is_ovf(v))
            return v[aw-1] ? $signed({1'b1, {(psum_bw-1){1'b0}}})
                           : $signed({1'b0, {(psum_bw-1){1'b1}}});
        return v[psum_bw-1:0];
    endfunction

    logic                       stall;
    logic [len_bw-1:0]          cnt;
    logic [len_bw-1:0]          len_q;
    logic [len_bw-1:0]          len_eff;
    logic                       first_beat;
    logic                       last_beat;
    logic signed [pw-1:0]       prod_c [lanes];

    logic                       vld_p1;
    logic                       first_p1;
    logic                       last_p1;
    logic signed [pw-1:0]       prod_p1 [lanes];
    logic signed [psum_bw-1:0]  c_in_p1;

    logic signed [sw-1:0]       lvl [lanes];
    logic signed [psum_bw-1:0]  base;
    logic signed [aw-1:0]       acc_nxt;
    logic signed [psum_bw-1:0]  acc_sat;
    logic                       grp_ovf_nxt;
    logic signed [psum_bw-1:0]  acc_p2;
    logic                       grp_ovf_p2;

    // A waiting psum freezes the whole pipe, so nothing can overtake it.
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    assign first_beat = (cnt == '0);
    assign len_eff    = (acc_len == '0) ? len_bw'(1) : acc_len;
    assign last_beat  = first_beat ? (len_eff == len_bw'(1)) : (cnt + len_bw'(1) == len_q);

    for (genvar i = 0; i < lanes; i++) begin : g_lane
        logic signed [bw:0]   a_ext;
        logic signed [bw-1:0] b_ext;
        assign a_ext     = act_signed ? $signed({a[i*bw+bw-1], a[i*bw +: bw]})
                                      : $signed({1'b0, a[i*bw +: bw]});
        assign b_ext     = $signed(b[i*bw +: bw]);
        assign prod_c[i] = pw'(a_ext) * pw'(b_ext);
    end

    // ---- stage 1: lane products plus group flags, captured on acceptance ----
    always_ff @(posedge clk) begin
        if (!stall && in_valid) begin
            prod_p1  <= prod_c;
            first_p1 <= first_beat;
            last_p1  <= last_beat;
            c_in_p1  <= $signed(c_in);
        end
    end

    // Balanced pairwise tree reduced in place; lvl[0] ends up holding the full sum.
    always_comb begin
        for (int i = 0; i < lanes; i++) lvl[i] = sw'(prod_p1[i]);
        for (int w = lanes / 2; w >= 1; w = w / 2)
            for (int k = 0; k < w; k++) lvl[k] = lvl[2*k] + lvl[2*k+1];
    end

    // ---- stage 2: accumulate, clamp or wrap, and publish on the last beat ----
    assign base        = first_p1 ? c_in_p1 : acc_p2;
    assign acc_nxt     = aw'(base) + aw'(lvl[0]);
    assign acc_sat     = sat_psum(acc_nxt);
    assign grp_ovf_nxt = (first_p1 ? 1'b0 : grp_ovf_p2) | is_ovf(acc_nxt);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            len_q      <= '0;
            vld_p1     <= 1'b0;
            acc_p2     <= '0;
            grp_ovf_p2 <= 1'b0;
            out_valid  <= 1'b0;
            out        <= '0;
            ovf        <= 1'b0;
        end else if (!stall) begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                cnt <= last_beat ? '0 : cnt + len_bw'(1);
                if (first_beat) len_q <= len_eff;
            end
            if (vld_p1) begin
                acc_p2     <= acc_sat;
                grp_ovf_p2 <= grp_ovf_nxt;
            end
            if (vld_p1 && last_p1) begin
                out       <= acc_sat;
                ovf       <= grp_ovf_nxt;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mac_acc_pipe.sv
// Randomised and directed bench for mac_acc_pipe, with saturating and wrapping instances
// checked against a group-level arithmetic model and a few literal psums.
module tb_mac_acc_pipe;
    localparam int BW = 4, PB = 16, LN = 4, LB = 8;

    logic clk = 0, reset = 1, in_valid = 0, out_ready = 1, act_signed = 0;
    logic [LN*BW-1:0] a = '0, b = '0;
    logic [PB-1:0] c_in = '0;
    logic [LB-1:0] acc_len = '0;
    logic in_ready_s, in_ready_w, out_valid_s, out_valid_w, ovf_s, ovf_w;
    logic [PB-1:0] out_s, out_w;

    mac_acc_pipe #(.bw(BW), .psum_bw(PB), .lanes(LN), .len_bw(LB), .sat_en(1'b1)) dut_s (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s), .a(a), .b(b),
        .c_in(c_in), .acc_len(acc_len), .act_signed(act_signed), .out_valid(out_valid_s),
        .out_ready(out_ready), .out(out_s), .ovf(ovf_s));
    mac_acc_pipe #(.bw(BW), .psum_bw(PB), .lanes(LN), .len_bw(LB), .sat_en(1'b0)) dut_w (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w), .a(a), .b(b),
        .c_in(c_in), .acc_len(acc_len), .act_signed(act_signed), .out_valid(out_valid_w),
        .out_ready(out_ready), .out(out_w), .ovf(ovf_w));

    always #5 clk = ~clk;

    typedef struct { int s; int w; int os; int ow; int cyc; } res_t;
    res_t exp_q[$];
    res_t lit_q[$];
    int total = 0, bad = 0;
    int ncyc = 0, m_cnt = 0, m_len = 0, m_acc_s = 0, m_acc_w = 0, m_ov_s = 0, m_ov_w = 0;
    int dot, av, bv, r;
    bit rst_prev = 0, lat_chk = 0, end_chk = 0, seen_front = 0, rand_rdy = 0;
    res_t fr, lt, ne;

    function automatic int wrapw(int v, int w);
        int m = v & ((1 << w) - 1);
        if (m >= (1 << (w - 1))) m -= (1 << w);
        return m;
    endfunction

    function automatic int lane(logic [LN*BW-1:0] v, int i);
        return int'(v[i*BW +: BW]);
    endfunction

    function automatic res_t mk(int s, int w, int os, int ow);
        res_t t;
        t.s = s; t.w = w; t.os = os; t.ow = ow; t.cyc = 0;
        return t;
    endfunction

    task automatic chk(string name, int act, int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, ncyc);
        end
    endtask

    // Single compare process: all checks and the reference model live here.
    always @(negedge clk) begin
        ncyc++;
        if (rst_prev) begin
            chk("rst_out_valid", int'(out_valid_s), 0);
            chk("rst_out", int'(out_s), 0);
            chk("rst_ovf", int'(ovf_s), 0);
            chk("rst_in_ready", int'(in_ready_s), 1);
            chk("rst_out_w", int'(out_w), 0);
        end
        chk("in_ready_s", int'(in_ready_s), int'(!(out_valid_s && !out_ready)));
        chk("in_ready_w", int'(in_ready_w), int'(!(out_valid_w && !out_ready)));
        if (exp_q.size() == 0) begin
            chk("spurious_s", int'(out_valid_s), 0);
            chk("spurious_w", int'(out_valid_w), 0);
        end else if (out_valid_s) begin
            fr = exp_q[0];
            chk("out_s", int'($signed(out_s)), fr.s);
            chk("ovf_s", int'(ovf_s), fr.os);
            chk("valid_w", int'(out_valid_w), 1);
            chk("out_w", int'($signed(out_w)), fr.w);
            chk("ovf_w", int'(ovf_w), fr.ow);
            if (lat_chk && !seen_front) chk("latency", ncyc - fr.cyc, 2);
            seen_front = 1;
            if (out_ready) begin
                if (lit_q.size() > 0) begin
                    lt = lit_q.pop_front();
                    chk("lit_out_s", int'($signed(out_s)), lt.s);
                    chk("lit_out_w", int'($signed(out_w)), lt.w);
                    chk("lit_ovf_s", int'(ovf_s), lt.os);
                    chk("lit_ovf_w", int'(ovf_w), lt.ow);
                end
                void'(exp_q.pop_front());
                seen_front = 0;
            end
        end
        if (end_chk) begin
            chk("drain_pending", exp_q.size(), 0);
            chk("drain_literals", lit_q.size(), 0);
        end
        rst_prev = reset;
        if (reset) begin
            exp_q.delete();
            m_cnt = 0;
            seen_front = 0;
        end else if (in_valid && in_ready_s) begin
            dot = 0;
            for (int i = 0; i < LN; i++) begin
                av = lane(a, i);
                if (act_signed && av >= 8) av -= 16;
                bv = lane(b, i);
                if (bv >= 8) bv -= 16;
                dot += av * bv;
            end
            if (m_cnt == 0) begin
                m_len = (acc_len == 0) ? 1 : int'(acc_len);
                m_acc_s = wrapw(int'(c_in), PB);
                m_acc_w = m_acc_s;
                m_ov_s = 0;
                m_ov_w = 0;
            end
            r = m_acc_s + dot;
            if (r > 32767) begin r = 32767; m_ov_s = 1; end
            else if (r < -32768) begin r = -32768; m_ov_s = 1; end
            m_acc_s = r;
            r = m_acc_w + dot;
            if (r > 32767 || r < -32768) m_ov_w = 1;
            m_acc_w = wrapw(r, PB);
            m_cnt++;
            if (m_cnt == m_len) begin
                ne = mk(m_acc_s, m_acc_w, m_ov_s, m_ov_w);
                ne.cyc = ncyc;
                exp_q.push_back(ne);
                m_cnt = 0;
            end
        end
    end

    task automatic step_rdy();
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic beat(input logic [15:0] av_i, input logic [15:0] bv_i, input logic [15:0] cv,
                        input int len, input bit as);
        bit took;
        int n = 0;
        in_valid = 1; a = av_i; b = bv_i; c_in = cv; acc_len = LB'(len); act_signed = as;
        do begin
            @(negedge clk);
            took = in_ready_s;
            @(posedge clk);
            #1;
            step_rdy();
            n++;
            if (n > 200) begin
                $display("FAIL beat_timeout: accepted=0 required=1");
                $fatal(1, "beat never accepted");
            end
        end while (!took);
        in_valid = 0;
    endtask

    task automatic idle(input int n);
        in_valid = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            step_rdy();
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 0;
        idle(2);

        // basic sum with latency
        lat_chk = 1;
        lit_q.push_back(mk(-1440, -1440, 0, 0));
        for (int i = 0; i < 3; i++) beat(16'hFFFF, 16'h8888, 16'd0, 3, 1'b0);
        idle(5);
        lat_chk = 0;

        // signed activations, acc_len 0 as 1, then a clean group
        lit_q.push_back(mk(37, 37, 0, 0));
        beat(16'hFFFF, 16'h8888, 16'd5, 0, 1'b1);
        lit_q.push_back(mk(4, 4, 0, 0));
        beat(16'h1111, 16'h1111, 16'd0, 1, 1'b0);
        idle(4);

        // overflow both directions, then a clean group
        lit_q.push_back(mk(32767, -32768, 1, 1));
        beat(16'h0001, 16'h0001, 16'd32767, 1, 1'b0);
        lit_q.push_back(mk(-32768, 32767, 1, 1));
        beat(16'h0001, 16'h000F, 16'h8000, 1, 1'b0);
        lit_q.push_back(mk(101, 101, 0, 0));
        beat(16'h0001, 16'h0001, 16'd100, 1, 1'b0);
        idle(4);

        // backpressure
        for (int k = 1; k <= 4; k++) lit_q.push_back(mk(k, k, 0, 0));
        fork
            begin
                for (int k = 1; k <= 4; k++) beat(16'(k), 16'h0001, 16'd0, 1, 1'b0);
            end
            begin
                out_ready = 0;
                repeat (6) @(posedge clk);
                #1 out_ready = 1;
            end
        join
        idle(4);

        // reset in the middle of a group
        beat(16'h0021, 16'h0011, 16'd7, 4, 1'b0);
        beat(16'h0021, 16'h0011, 16'd7, 4, 1'b0);
        reset = 1;
        @(posedge clk);
        #1 reset = 0;
        lit_q.push_back(mk(16, 16, 0, 0));
        beat(16'h0321, 16'h0111, 16'd10, 1, 1'b0);
        idle(4);

        // bubbles, later-beat acc_len/c_in ignored
        lit_q.push_back(mk(31, 31, 0, 0));
        beat(16'h0003, 16'h0002, 16'd20, 2, 1'b0);
        idle(3);
        beat(16'h0005, 16'h0001, 16'd999, 7, 1'b0);
        idle(4);

        // random groups under random backpressure
        rand_rdy = 1;
        for (int g = 0; g < 60; g++) begin
            int len = $urandom_range(0, 5);
            int nb = (len == 0) ? 1 : len;
            for (int j = 0; j < nb; j++) begin
                int sel = $urandom_range(0, 2);
                logic [15:0] cv = (sel == 0) ? 16'($urandom) :
                                  (sel == 1) ? 16'($urandom_range(32512, 32767)) :
                                               16'($urandom_range(32768, 33023));
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                beat(16'($urandom), 16'($urandom), cv, (j == 0) ? len : $urandom_range(0, 255),
                     1'($urandom_range(0, 1)));
            end
        end
        // longest legal group
        for (int j = 0; j < 255; j++)
            beat(16'($urandom), 16'($urandom), 16'd1000, (j == 0) ? 255 : 3, 1'($urandom_range(0, 1)));

        rand_rdy = 0;
        out_ready = 1;
        idle(10);
        end_chk = 1;
        repeat (2) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
